prog_clk_div: RTL and testbench

Programmable modulo counter and clock divider with a runtime-loadable divisor. Counts `0..div-1` while enabled and produces two outputs: a one-cycle terminal-count `tick` and a near-50% duty `clk_div` square wave. A new divisor is loaded through a valid/ready handshake and takes effect without glitches. Used as the shared clock-enable generator for the lab designs. It replaces fixed-modulo counters that tap an MSB.

---
 rtl/prog_clk_div_pkg.sv | 8 +
 rtl/div_shadow_reg.sv | 53 +++++
 rtl/prog_clk_div.sv | 90 +++++++++
 tb/tb_prog_clk_div.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/prog_clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package prog_clk_div_pkg;

  typedef enum logic {IDLE, PENDING} pcd_state_t;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/div_shadow_reg.sv
// Divisor load handshake: clamps and captures a requested divisor, then holds it
// pending until the counter applies it.
module div_shadow_reg
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] div_i,
  input  logic             div_valid,
  input  logic             apply_i,
  output logic             div_ready,
  output logic             pending_o,
  output logic [WIDTH-1:0] div_shadow_o
);

  pcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= WIDTH'(MIN_DIV);
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    unique case (state_q)
      IDLE: begin
        if (div_valid) begin
          // Divisors below the minimum would never wrap cleanly; store the minimum.
          shadow_d = (div_i < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : div_i;
          state_d  = PENDING;
        end
      end
      PENDING: begin
        if (apply_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign div_ready    = (state_q == IDLE);
  assign pending_o    = (state_q == PENDING);
  assign div_shadow_o = shadow_q;

endmodule

// File: rtl/prog_clk_div.sv
// Programmable modulo counter / clock divider with glitch-free divisor reload.
// Optional synchronous clear port enabled by defining PCD_SYNC_CLR_EN.
module prog_clk_div
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_i,
  input  logic             div_valid,
  output logic             div_ready,
  output logic [WIDTH-1:0] cont,
  output logic             tick,
  output logic             clk_div
`ifdef PCD_SYNC_CLR_EN
  ,
  input  logic             clr
`endif
);

  logic [WIDTH-1:0] cont_q, cont_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] div_shadow;
  logic             tick_q, tick_d;
  logic             clk_div_q, clk_div_d;
  logic             pending, apply, wrap, clr_w;

`ifdef PCD_SYNC_CLR_EN
  assign clr_w = clr;
`else
  assign clr_w = 1'b0;
`endif

  div_shadow_reg #(
    .WIDTH(WIDTH)
  ) u_div_shadow_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_i       (div_i),
    .div_valid   (div_valid),
    .apply_i     (apply),
    .div_ready   (div_ready),
    .pending_o   (pending),
    .div_shadow_o(div_shadow)
  );

  always_comb begin
    wrap      = en && (cont_q == (div_q - 1'b1));
    // A pending divisor lands on a wrap, immediately when idle-disabled, or on clear.
    apply     = pending && (clr_w || !en || wrap);
    div_d     = apply ? div_shadow : div_q;
    cont_d    = cont_q;
    tick_d    = 1'b0;
    clk_div_d = clk_div_q;
    if (clr_w) begin
      cont_d    = '0;
      clk_div_d = 1'b0;
    end else if (apply && !en) begin
      cont_d    = '0;
      clk_div_d = 1'b0;
    end else if (en) begin
      cont_d    = wrap ? '0 : cont_q + 1'b1;
      tick_d    = wrap;
      // Derived from next-state values so the edge lines up with cont.
      clk_div_d = (cont_d >= (div_d >> 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q    <= '0;
      div_q     <= WIDTH'(DEFAULT_DIV);
      tick_q    <= 1'b0;
      clk_div_q <= 1'b0;
    end else begin
      cont_q    <= cont_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      clk_div_q <= clk_div_d;
    end
  end

  assign cont    = cont_q;
  assign tick    = tick_q;
  assign clk_div = clk_div_q;

endmodule

// File: tb/tb_prog_clk_div.sv
// Randomized bench for prog_clk_div against a behavioural count-modulo model.
module tb_prog_clk_div;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] div_i = '0;
  logic         div_valid = 1'b0;
  logic         div_ready;
  logic [W-1:0] cont;
  logic         tick;
  logic         clk_div;
`ifdef PCD_SYNC_CLR_EN
  logic         clr = 1'b0;
`endif

  prog_clk_div #(
    .WIDTH      (W),
    .DEFAULT_DIV(10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_i    (div_i),
    .div_valid(div_valid),
    .div_ready(div_ready),
    .cont     (cont),
    .tick     (tick),
    .clk_div  (clk_div)
`ifdef PCD_SYNC_CLR_EN
    ,
    .clr      (clr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int unsigned m_cont, m_div, m_shadow;
  bit          m_pend, m_tick, m_clkdiv;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_cont = 0; m_div = 10; m_shadow = 2; m_pend = 0; m_tick = 0; m_clkdiv = 0;
  endfunction

  function automatic void model_step(input bit e, input bit v, input int unsigned d);
    bit was_pend = m_pend;
    if (was_pend && !e) begin
      m_cont = 0; m_div = m_shadow; m_pend = 0; m_tick = 0;
    end else if (e) begin
      m_cont = (m_cont + 1) % m_div;
      m_tick = (m_cont == 0);
      if (m_tick && was_pend) begin
        m_div = m_shadow; m_pend = 0;
      end
    end else begin
      m_tick = 0;
    end
    if (!was_pend && v) begin
      m_pend = 1;
      m_shadow = (d < 2) ? 2 : d;
    end
    m_clkdiv = (m_cont >= m_div / 2);
  endfunction

  task automatic check_all();
    check_eq("cont", 32'(cont), m_cont);
    check_eq("tick", 32'(tick), 32'(m_tick));
    check_eq("clk_div", 32'(clk_div), 32'(m_clkdiv));
    check_eq("div_ready", 32'(div_ready), 32'(!m_pend));
  endtask

  // Called at a negedge: drive inputs, advance one edge, compare at the next negedge.
  task automatic run_cycle(input bit e, input bit v, input int unsigned d);
    en = e; div_valid = v; div_i = W'(d);
    @(posedge clk);
    if (rst_n) model_step(e, v, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_cont", 32'(cont), 0);
    check_eq("rst_tick", 32'(tick), 0);
    check_eq("rst_clk_div", 32'(clk_div), 0);
    check_eq("rst_ready", 32'(div_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ticks;
    model_reset();
    #2;
    check_eq("rst_cont", 32'(cont), 0);
    check_eq("rst_ready", 32'(div_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Default divisor: ticks at cycles 10, 20, 30
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      run_cycle(1, 0, 0);
      if (tick) ticks++;
    end
    check_eq("default_tick_count", 32'(ticks), 3);

    // Load 4 at count 3
    for (int i = 0; i < 50 && m_cont != 3; i++) run_cycle(1, 0, 0);
    check_eq("reach_cont3", 32'(cont), 3);
    run_cycle(1, 1, 4);
    check_eq("ready_low_after_accept", 32'(div_ready), 0);
    for (int i = 0; i < 20; i++) run_cycle(1, 0, 0);

    // Odd divisor, then clamp
    run_cycle(1, 1, 5);
    for (int i = 0; i < 20; i++) run_cycle(1, 0, 0);
    run_cycle(1, 1, 0);
    for (int i = 0; i < 12; i++) run_cycle(1, 0, 0);

    // Load while disabled at count 7
    run_cycle(1, 1, 12);
    for (int i = 0; i < 60 && !(m_cont == 7 && !m_pend); i++) run_cycle(1, 0, 0);
    check_eq("reach_cont7", 32'(cont), 7);
    run_cycle(0, 1, 6);
    run_cycle(0, 0, 0);
    check_eq("disabled_load_cont", 32'(cont), 0);
    check_eq("disabled_load_ready", 32'(div_ready), 1);
    check_eq("disabled_load_tick", 32'(tick), 0);
    for (int i = 0; i < 15; i++) run_cycle(1, 0, 0);

    // Reset while pending: default divisor restored
    for (int i = 0; i < 20 && m_cont != 1; i++) run_cycle(1, 0, 0);
    run_cycle(1, 1, 3);
    check_eq("pending_before_reset", 32'(div_ready), 0);
    do_reset();
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      run_cycle(1, 0, 0);
      if (tick) ticks++;
    end
    check_eq("post_reset_tick_count", 32'(ticks), 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else run_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 12));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
